// File: rtl/cobra_ctrl_pkg.sv
// CYBERcobra run controller: shared state encoding and request helpers.
// Optional cycle budget is enabled with COBRA_CYCLE_LIMIT_EN.
package cobra_ctrl_pkg;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      IDLE  = 2'd1,
      RUN   = 2'd2,
      HALT  = 2'd3
   } run_state_t;

   localparam int REQ_W = 4;

   // Bit positions in the request vector; a higher index wins a tie.
   localparam int REQ_RUN  = 0;
   localparam int REQ_STEP = 1;
   localparam int REQ_HALT = 2;
   localparam int REQ_CLR  = 3;

   typedef logic [REQ_W-1:0] req_t;

   // Keep only the highest-priority request of those present.
   function automatic req_t req_pick(input req_t r);
      req_t p;
      p = '0;
      for (int i = 0; i < REQ_W; i++) begin
         if (r[i]) p = req_t'(1) << i;
      end
      return p;
   endfunction

endpackage

// File: rtl/cobra_req_edge.sv
// Request input register with rising-edge pulse output.
// Held levels produce a single pulse.
module cobra_req_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   output logic pulse_o
);

   logic req_q;
   logic prev_q;

   // Register the raw request and remember its previous value.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         req_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         req_q  <= req_i;
         prev_q <= req_q;
      end
   end

   assign pulse_o = req_q & ~prev_q;

endmodule

// File: rtl/cobra_run_ctrl.sv
// Run/step/halt sequencer for the CYBERcobra core.
// Define COBRA_CYCLE_LIMIT_EN to halt after MAX_CYCLES enabled cycles.
module cobra_run_ctrl
   import cobra_ctrl_pkg::*;
#(
   parameter int unsigned PC_W       = 32,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MAX_CYCLES = 10000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             step_i,
   input  logic             halt_i,
   input  logic             clr_i,
   input  logic             bp_en_i,
   input  logic [PC_W-1:0]  bp_addr_i,
   input  logic [PC_W-1:0]  pc_i,
   input  logic [31:0]      core_out_i,
   output logic             cpu_en_o,
   output logic             cpu_rst_o,
   output logic [1:0]       state_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [31:0]      out_latch_o
);

   run_state_t       state_q, state_d;
   logic             step_q, step_d;
   logic             skip_q, skip_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      lat_q, lat_d;

   req_t             req;
   req_t             avail;
   req_t             sel;
   logic             bp_hit;
   logic             lim_hit;
   logic             stop;
   logic             en;

   cobra_req_edge u_run (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (run_i),
      .pulse_o (req[REQ_RUN])
   );

   cobra_req_edge u_step (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (step_i),
      .pulse_o (req[REQ_STEP])
   );

   cobra_req_edge u_halt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (halt_i),
      .pulse_o (req[REQ_HALT])
   );

   cobra_req_edge u_clr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (clr_i),
      .pulse_o (req[REQ_CLR])
   );

`ifdef COBRA_CYCLE_LIMIT_EN
   assign lim_hit = (cnt_q >= CNT_W'(MAX_CYCLES));
`else
   assign lim_hit = 1'b0;
`endif

   // The first enabled cycle after leaving HALT ignores the breakpoint.
   assign bp_hit = bp_en_i && (pc_i == bp_addr_i) && !skip_q;

   // Next-state, core enable, counter and latch updates.
   always_comb begin
      state_d = state_q;
      step_d  = 1'b0;
      skip_d  = skip_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      avail   = '0;
      stop    = 1'b0;
      en      = 1'b0;

      unique case (state_q)
         RESET: begin
            state_d = IDLE;
            skip_d  = 1'b0;
            cnt_d   = '0;
            lat_d   = '0;
         end
         IDLE: begin
            avail[REQ_CLR]  = 1'b1;
            avail[REQ_STEP] = 1'b1;
            avail[REQ_RUN]  = 1'b1;
         end
         RUN: begin
            avail[REQ_CLR]  = 1'b1;
            avail[REQ_HALT] = 1'b1;
         end
         HALT: begin
            avail[REQ_CLR]  = 1'b1;
            avail[REQ_STEP] = 1'b1;
            avail[REQ_RUN]  = !lim_hit;
         end
      endcase

      sel = req_pick(req & avail);

      unique case (1'b1)
         sel[REQ_CLR]:  state_d = RESET;
         sel[REQ_HALT]: state_d = HALT;
         sel[REQ_STEP]: step_d  = 1'b1;
         sel[REQ_RUN]: begin
            state_d = RUN;
            skip_d  = (state_q == HALT);
         end
         default: ;
      endcase

      if (state_q == RUN) begin
         stop = (sel != '0) || bp_hit || lim_hit;
         if (sel == '0 && (bp_hit || lim_hit)) state_d = HALT;
      end

      en = ((state_q == RUN) && !stop) || step_q;

      if (en) begin
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         if (state_q == RUN) skip_d = 1'b0;
      end

      if (state_q == RUN && state_d == HALT) lat_d = core_out_i;
      if (state_q == HALT && step_q) lat_d = core_out_i;

      if (sel[REQ_CLR]) begin
         cnt_d  = '0;
         lat_d  = '0;
         skip_d = 1'b0;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= RESET;
         step_q  <= 1'b0;
         skip_q  <= 1'b0;
         cnt_q   <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         skip_q  <= skip_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
      end
   end

   assign cpu_en_o    = en;
   assign cpu_rst_o   = (state_q == RESET);
   assign state_o     = state_q;
   assign halted_o    = (state_q == HALT);
   assign cycle_cnt_o = cnt_q;
   assign out_latch_o = lat_q;

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Directed bench for cobra_run_ctrl with a tiny PC-stepping core model.
// Build with COBRA_CYCLE_LIMIT_EN to exercise the cycle budget.
module tb_cobra_run_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run_i, step_i, halt_i, clr_i;
   logic        bp_en;
   logic [31:0] bp_addr;
   logic [31:0] pc;
   logic [31:0] core_out;
   logic        cpu_en, cpu_rst, halted;
   logic [1:0]  state;
   logic [31:0] cnt;
   logic [31:0] latch;

   int errs = 0;
   int checks = 0;
   int hits;

   cobra_run_ctrl #(
      .PC_W       (32),
      .CNT_W      (32),
      .MAX_CYCLES (100)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .run_i       (run_i),
      .step_i      (step_i),
      .halt_i      (halt_i),
      .clr_i       (clr_i),
      .bp_en_i     (bp_en),
      .bp_addr_i   (bp_addr),
      .pc_i        (pc),
      .core_out_i  (core_out),
      .cpu_en_o    (cpu_en),
      .cpu_rst_o   (cpu_rst),
      .state_o     (state),
      .halted_o    (halted),
      .cycle_cnt_o (cnt),
      .out_latch_o (latch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core stand-in: PC advances by 4 per enabled cycle.
   always @(posedge clk) begin
      if (!rst_n || cpu_rst) pc <= '0;
      else if (cpu_en) pc <= pc + 32'd4;
   end

   assign core_out = pc ^ 32'hC0B0_0000;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr_i = 1'b1;
      tick(2);
      clr_i = 1'b0;
      tick(3);
   endtask

   initial begin
      rst_n   = 1'b0;
      run_i   = 1'b0;
      step_i  = 1'b0;
      halt_i  = 1'b0;
      clr_i   = 1'b0;
      bp_en   = 1'b0;
      bp_addr = '0;
      pc      = '0;
      tick(3);

      chk("rst_state", state, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_halted", halted, 0);

      // reset release: one cycle of core reset, then IDLE
      rst_n = 1'b1;
      #1 chk("rel_cpu_rst_hi", cpu_rst, 1);
      tick(1);
      chk("rel_cpu_rst_lo", cpu_rst, 0);
      chk("rel_state", state, 1);
      chk("rel_cpu_en", cpu_en, 0);
      chk("rel_cnt", cnt, 0);

      // held step gives one enabled cycle
      step_i = 1'b1;
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (cpu_en) hits++;
      end
      step_i = 1'b0;
      chk("step_pulses", hits, 1);
      chk("step_cnt", cnt, 1);
      chk("step_state", state, 1);

      // halt in IDLE is dropped
      halt_i = 1'b1;
      tick(4);
      halt_i = 1'b0;
      tick(2);
      chk("idle_halt_drop", state, 1);

      pulse_clr();
      chk("clr_idle_cnt", cnt, 0);
      chk("clr_idle_state", state, 1);

      // run, then halt after 37 executed cycles
      run_i = 1'b1;
      tick(38);
      halt_i = 1'b1;
      tick(4);
      chk("halt_cnt", cnt, 37);
      chk("halt_flag", halted, 1);
      chk("halt_state", state, 3);
      chk("halt_latch", latch, 32'hC0B0_0094);
      chk("halt_cpu_en", cpu_en, 0);
      run_i  = 1'b0;
      halt_i = 1'b0;
      tick(2);

      // two steps from HALT, latch follows each step
      for (int s = 0; s < 2; s++) begin
         step_i = 1'b1;
         tick(3);
         step_i = 1'b0;
         tick(2);
      end
      chk("hstep_cnt", cnt, 39);
      chk("hstep_state", state, 3);
      chk("hstep_latch", latch, 32'hC0B0_0098);

      pulse_clr();
      chk("clr_halt_cnt", cnt, 0);
      chk("clr_halt_latch", latch, 0);
      chk("clr_halt_pc", pc, 0);

      // breakpoint at 0x10
      bp_en   = 1'b1;
      bp_addr = 32'h10;
      run_i   = 1'b1;
      tick(12);
      chk("bp_state", state, 3);
      chk("bp_pc", pc, 32'h10);
      chk("bp_cnt", cnt, 4);
      chk("bp_latch", latch, 32'hC0B0_0010);
      run_i = 1'b0;
      tick(2);
      run_i = 1'b1;
      tick(6);
      chk("bp_resume_state", state, 2);
      chk("bp_resume_cnt", cnt, 8);
      chk("bp_resume_pc", pc, 32'h20);

      // halt and clr together: clr wins
      halt_i = 1'b1;
      clr_i  = 1'b1;
      hits = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (cpu_rst) hits++;
      end
      halt_i = 1'b0;
      clr_i  = 1'b0;
      chk("hc_rst_pulses", hits, 1);
      chk("hc_state", state, 1);
      chk("hc_cnt", cnt, 0);
      chk("hc_halted", halted, 0);
      bp_en = 1'b0;
      run_i = 1'b0;
      tick(2);

`ifdef COBRA_CYCLE_LIMIT_EN
      run_i = 1'b1;
      tick(110);
      chk("lim_state", state, 3);
      chk("lim_cnt", cnt, 100);
      run_i = 1'b0;
      tick(2);
      run_i = 1'b1;
      tick(5);
      chk("lim_rerun_state", state, 3);
      chk("lim_rerun_cnt", cnt, 100);
      run_i = 1'b0;
      pulse_clr();
      chk("lim_clr_cnt", cnt, 0);
      run_i = 1'b1;
      tick(6);
      chk("lim_restart_state", state, 2);
      chk("lim_restart_cnt", cnt, 4);
`else
      run_i = 1'b1;
      tick(110);
      chk("nolim_state", state, 2);
      chk("nolim_cnt", cnt, 108);
`endif

      // asynchronous reset in the middle of a run
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_cnt", cnt, 0);
      chk("arst_cpu_en", cpu_en, 0);
      chk("arst_cpu_rst", cpu_rst, 1);
      chk("arst_latch", latch, 0);
      run_i = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
